// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: state encoding and
// per-board default timing constants.
package btn_pkg;

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_DN_PEND = 2'd1,
    S_DOWN    = 2'd2,
    S_UP_PEND = 2'd3
  } btn_state_e;

  // 10 ms debounce and 2 s long-press at each board clock
  localparam int unsigned DEBOUNCE_CYCLES_125M = 1_250_000;
  localparam int unsigned DEBOUNCE_CYCLES_100M = 1_000_000;
  localparam int unsigned LONG_CYCLES_125M     = 250_000_000;
  localparam int unsigned LONG_CYCLES_100M     = 200_000_000;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered
// level/press/release outputs and, with BTN_LONG_PRESS_EN defined, the
// hold counter driving btn_long.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int unsigned DB_W            = 21,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_125M,
  parameter int unsigned LONG_W          = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1, sync2;
  btn_state_e      state, state_d;
  logic [DB_W-1:0] cnt, cnt_d;
  logic            press_d, release_d, level_d;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // FSM state, debounce counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_UP;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  // Next state: a level change is accepted only after it holds long enough
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      S_UP: begin
        if (sync2) begin
          state_d = S_DN_PEND;
          cnt_d   = '0;
        end
      end
      S_DN_PEND: begin
        if (!sync2) begin
          state_d = S_UP;
        end else if (cnt == CNT_LAST) begin
          state_d = S_DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt + DB_W'(1);
        end
      end
      S_DOWN: begin
        if (!sync2) begin
          state_d = S_UP_PEND;
          cnt_d   = '0;
        end
      end
      S_UP_PEND: begin
        if (sync2) begin
          state_d = S_DOWN;
        end else if (cnt == CNT_LAST) begin
          state_d   = S_UP;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt + DB_W'(1);
        end
      end
      default: state_d = S_UP;
    endcase
    level_d = (state_d == S_DOWN) || (state_d == S_UP_PEND);
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_cnt;
  logic              long_done;
  logic              held;
  logic              long_d;

  assign held   = (state == S_DOWN) || (state == S_UP_PEND);
  // Fire once per press; a pulse colliding with the release is dropped
  assign long_d = held && (hold_cnt == HOLD_LAST) && !long_done && !release_d;

  // Hold counter: cleared on press, saturates, survives bounces
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      btn_long  <= 1'b0;
    end else begin
      btn_long <= long_d;
      if (press_d) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else begin
        if (held && (hold_cnt != HOLD_LAST)) hold_cnt <= hold_cnt + LONG_W'(1);
        if (long_d) long_done <= 1'b1;
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^{LONG_CYCLES, LONG_W};
  assign btn_long        = 1'b0;
`endif

endmodule : btn_debounce_ch

// File: rtl/btn_cond.sv
// Push-button conditioner: N_BTN independent debounce channels.
// Optional long-press pulse enabled by defining BTN_LONG_PRESS_EN.
module btn_cond
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_125M,
  parameter int unsigned DB_W            = 21,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_125M,
  parameter int unsigned LONG_W          = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  // One identical conditioner per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W),
      .LONG_CYCLES     (LONG_CYCLES),
      .LONG_W          (LONG_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule : btn_cond

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: directed scenarios plus random bouncing, checked
// per cycle against a run-length reference model through a queue.
module tb_btn_cond;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LC = 16;

  typedef struct packed {
    logic [N-1:0] lng;
    logic [N-1:0] rls;
    logic [N-1:0] prs;
    logic [N-1:0] lvl;
  } out_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  btn_cond #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DB),
    .DB_W            (3),
    .LONG_CYCLES     (LC),
    .LONG_W          (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  // Reference model: pin delayed two samples, accepted level flips after
  // DB+1 consecutive disagreeing samples, long after LC held edges.
  logic m_s1[N], m_s2[N], m_lvl[N], m_fired[N];
  int   m_run[N], m_held[N];

  task automatic model_edge(input logic [N-1:0] raw, input logic rst, output out_t e);
    e = '0;
    for (int c = 0; c < N; c++) begin
      logic seen, was, pr, rl, lg;
      if (rst) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0; m_held[c] = 0; m_fired[c] = 1'b0;
      end else begin
        seen = m_s2[c];
        was  = m_lvl[c];
        pr = 1'b0; rl = 1'b0; lg = 1'b0;
        if (seen != was) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c] = seen;
            m_run[c] = 0;
            pr = seen;
            rl = !seen;
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef BTN_LONG_PRESS_EN
        if (was && !rl) begin
          if (m_held[c] < LC) m_held[c]++;
          if (m_held[c] == LC && !m_fired[c]) begin
            lg = 1'b1;
            m_fired[c] = 1'b1;
          end
        end
        if (pr) begin
          m_held[c]  = 0;
          m_fired[c] = 1'b0;
        end
`endif
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
        e.lvl[c] = m_lvl[c];
        e.prs[c] = pr;
        e.rls[c] = rl;
        e.lng[c] = lg;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic rst);
    out_t e;
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation each cycle
  initial begin
    out_t e, act;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {btn_long, btn_release, btn_press, btn_level};
        n_cmp++;
        if (act !== e) begin
          n_mis++;
          $display("FAIL outputs cyc=%0d: got lvl=%b prs=%b rls=%b lng=%b, expected lvl=%b prs=%b rls=%b lng=%b",
                   cyc, act.lvl, act.prs, act.rls, act.lng, e.lvl, e.prs, e.rls, e.lng);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    int           rem[N];
    int           wait_cyc;
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) step(2'b00, 1'b1);

    // clean press then release
    hold(2'b01, 40);
    hold(2'b00, 20);
    // bounce before a steady press
    hold(2'b01, 2); hold(2'b00, 1); hold(2'b01, 30); hold(2'b00, 20);
    // short glitch rejected
    hold(2'b01, 3); hold(2'b00, 15);
    // long press with a one-cycle low bounce around hold cycle 10
    hold(2'b01, 16); hold(2'b00, 1); hold(2'b01, 30); hold(2'b00, 20);
    // reset while a press is pending, button still held afterwards
    hold(2'b01, 4); step(2'b01, 1'b1); step(2'b01, 1'b1);
    hold(2'b01, 20); hold(2'b00, 20);
    // both channels together, release only channel 1
    hold(2'b11, 20); hold(2'b01, 20); hold(2'b00, 20);

    // random bouncing with occasional long holds and resets
    r = '0;
    for (int c = 0; c < N; c++) rem[c] = int'($urandom_range(1, 8));
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          r[c]   = ~r[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                               : int'($urandom_range(1, 7));
        end
        rem[c]--;
      end
      step(r, $urandom_range(0, 199) == 0);
    end
    hold(2'b00, 20);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_btn_cond
